// File: rtl/code_gen_ntap.sv
// code_gen_ntap: C/A code generator for one tracking channel with a
// configurable number of half-chip-spaced taps, dump point, code length
// and a data-bit epoch counter captured at the TIC.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   tic_enable       TIC pulse, captures code_phase and epoch_at_tic
//   hc_enable        half-chip pulse from the code NCO
//   prn_key_enable   re-initialise, loads G2 from prn_key (highest priority)
//   prn_key          G2 initial state
//   slew_enable      arms a slew of code_slew half-chips for the next period
//   code_slew        slew length in half-chips
//   epoch_load       loads epoch from epoch_load_val
//   epoch_load_val   epoch load value
//   taps             code taps, bit 0 earliest
//   early/prompt/late  the three centre taps
//   dump_enable      one-cycle pulse per code period
//   code_phase       half-chips since last dump, captured at TIC
//   epoch            live epoch count
//   epoch_at_tic     epoch captured at TIC
//   slew_busy        slew armed or in progress
module code_gen_ntap #(
  parameter int TAPS        = 3,
  parameter int HC_PER_CODE = 2046,
  parameter int DUMP_HC     = 3,
  parameter int EPOCH_LEN   = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tic_enable,
  input  logic            hc_enable,
  input  logic            prn_key_enable,
  input  logic [9:0]      prn_key,
  input  logic            slew_enable,
  input  logic [10:0]     code_slew,
  input  logic            epoch_load,
  input  logic [4:0]      epoch_load_val,
  output logic [TAPS-1:0] taps,
  output logic            early,
  output logic            prompt,
  output logic            late,
  output logic            dump_enable,
  output logic [11:0]     code_phase,
  output logic [4:0]      epoch,
  output logic [4:0]      epoch_at_tic,
  output logic            slew_busy
);

  localparam logic [11:0] MAX_HC     = 12'(HC_PER_CODE - 1);
  localparam logic [11:0] DUMP_CNT   = 12'(DUMP_HC);
  localparam logic [4:0]  EPOCH_LAST = 5'(EPOCH_LEN - 1);

  logic        running;
  logic [9:0]  g1, g2;
  logic        g1_q, g2_q, ca;
  logic        hc_count1, fc_enable;
  logic [11:0] hc_count2, max_count2, hc_count3;
  logic        slew_trigger, slew_flag, slew_flag_nxt;
  logic [10:0] slew, slew_nxt;
  logic        hc_go;

  // Nothing advances between reset and the first prn_key_enable.
  assign hc_go  = hc_enable & running;
  assign ca     = g1_q ^ g2_q;
  assign early  = taps[TAPS/2-1];
  assign prompt = taps[TAPS/2];
  assign late   = taps[TAPS/2+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 running <= 1'b0;
    else if (prn_key_enable) running <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= '0; g2 <= '0; g1_q <= 1'b0; g2_q <= 1'b0;
    end else if (prn_key_enable) begin
      g1 <= 10'h3FF; g2 <= prn_key; g1_q <= 1'b0; g2_q <= 1'b0;
    end else if (fc_enable) begin
      g1_q <= g1[0];
      g1   <= {g1[7] ^ g1[0], g1[9:1]};
      g2_q <= g2[0];
      g2   <= {g2[8] ^ g2[7] ^ g2[4] ^ g2[2] ^ g2[1] ^ g2[0], g2[9:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 taps <= '0;
    else if (prn_key_enable) taps <= '0;
    else if (hc_go)          taps <= {taps[TAPS-2:0], ca};
  end

  // Slew: every hc_enable spent while slew != 0 freezes the chip toggle,
  // delaying the code by one half-chip. A trigger load overrides the
  // decrement.
  always_comb begin
    slew_nxt = slew;
    if (hc_go && slew != 11'd0) slew_nxt = slew - 11'd1;
    if (slew_trigger)           slew_nxt = code_slew;
    slew_flag_nxt = slew_flag;
    if (dump_enable) slew_flag_nxt = 1'b0;
    if (slew_enable) slew_flag_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_count1 <= 1'b0; fc_enable <= 1'b0;
      slew <= '0; slew_flag <= 1'b0; slew_busy <= 1'b0;
    end else if (prn_key_enable) begin
      hc_count1 <= 1'b0; fc_enable <= 1'b0;
      slew <= '0; slew_flag <= 1'b0; slew_busy <= 1'b0;
    end else begin
      fc_enable <= 1'b0;
      if (hc_go && slew == 11'd0) begin
        hc_count1 <= ~hc_count1;
        fc_enable <= hc_count1;
      end
      slew      <= slew_nxt;
      slew_flag <= slew_flag_nxt;
      slew_busy <= slew_flag_nxt | (slew_nxt != 11'd0);
    end
  end

  // Period counter. The period length for the coming wrap is chosen at
  // count 1, so an armed slew stretches the period it is triggered in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc_count2 <= '0; max_count2 <= '0;
      dump_enable <= 1'b0; slew_trigger <= 1'b0;
    end else if (prn_key_enable) begin
      hc_count2 <= '0; max_count2 <= MAX_HC;
      dump_enable <= 1'b0; slew_trigger <= 1'b0;
    end else begin
      dump_enable  <= 1'b0;
      slew_trigger <= 1'b0;
      if (hc_go) begin
        hc_count2 <= hc_count2 + 12'd1;
        if (hc_count2 == DUMP_CNT) begin
          dump_enable <= 1'b1;
        end else if (hc_count2 == max_count2) begin
          hc_count2 <= '0;
        end else if (hc_count2 == 12'd1) begin
          if (slew_flag) begin
            slew_trigger <= 1'b1;
            max_count2   <= MAX_HC + {1'b0, code_slew};
          end else begin
            max_count2   <= MAX_HC;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 hc_count3 <= '0;
    else if (prn_key_enable) hc_count3 <= '0;
    else if (dump_enable)    hc_count3 <= '0;
    else if (hc_go)          hc_count3 <= hc_count3 + 12'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch <= '0;
    end else if (prn_key_enable) begin
      epoch <= '0;
    end else if (epoch_load) begin
      epoch <= epoch_load_val;
    end else if (dump_enable) begin
      epoch <= (epoch == EPOCH_LAST) ? 5'd0 : epoch + 5'd1;
    end
  end

  // Captures see the pre-update counters when a TIC lands on a dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_phase <= '0; epoch_at_tic <= '0;
    end else if (tic_enable && !prn_key_enable) begin
      code_phase   <= hc_count3;
      epoch_at_tic <= epoch;
    end
  end

endmodule

// File: tb/tb_code_gen_ntap.sv
module tb_code_gen_ntap;
  localparam int TAPS = 5;
  localparam int HC   = 2046;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            tic_enable = 1'b0, hc_enable = 1'b0, prn_key_enable = 1'b0;
  logic [9:0]      prn_key = '0;
  logic            slew_enable = 1'b0;
  logic [10:0]     code_slew = '0;
  logic            epoch_load = 1'b0;
  logic [4:0]      epoch_load_val = '0;
  logic [TAPS-1:0] taps;
  logic            early, prompt, late, dump_enable, slew_busy;
  logic [11:0]     code_phase;
  logic [4:0]      epoch, epoch_at_tic;

  code_gen_ntap #(.TAPS(TAPS), .HC_PER_CODE(HC), .DUMP_HC(3), .EPOCH_LEN(20)) dut (
    .clk(clk), .rst(rst), .tic_enable(tic_enable), .hc_enable(hc_enable),
    .prn_key_enable(prn_key_enable), .prn_key(prn_key), .slew_enable(slew_enable),
    .code_slew(code_slew), .epoch_load(epoch_load), .epoch_load_val(epoch_load_val),
    .taps(taps), .early(early), .prompt(prompt), .late(late),
    .dump_enable(dump_enable), .code_phase(code_phase), .epoch(epoch),
    .epoch_at_tic(epoch_at_tic), .slew_busy(slew_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Independent C/A reference: PRN 1 via the G2 phase selector (stages 2 and 6).
  logic ca_ref [0:1022];
  task automatic build_ca();
    logic [10:1] a, b;
    logic f1, f2;
    a = '1; b = '1;
    for (int i = 0; i < 1023; i++) begin
      ca_ref[i] = a[10] ^ b[2] ^ b[6];
      f1 = a[3] ^ a[10];
      f2 = b[2] ^ b[3] ^ b[6] ^ b[8] ^ b[9] ^ b[10];
      a = {a[9:1], f1};
      b = {b[9:1], f2};
    end
  endtask

  function automatic logic exp_chip(int idx);
    logic [9:0] first10 = 10'b1100100000;
    if (idx < 10) return first10[9-idx];
    return ca_ref[idx];
  endfunction

  // Tap k after edge m (m counted from the prn_key load edge, s = total slew):
  // chip index (m-4-k-s)/2, zero before the first chip arrives.
  function automatic logic [TAPS-1:0] exp_taps(int m, int s);
    logic [TAPS-1:0] r = '0;
    for (int k = 0; k < TAPS; k++) begin
      int j = m - 4 - k - s;
      if (j >= 0) r[k] = exp_chip((j / 2) % 1023);
    end
    return r;
  endfunction

  typedef struct { int unsigned at; logic [TAPS-1:0] v; } tap_exp_t;
  tap_exp_t    tap_q[$];
  int          dump_q[$];
  int unsigned last_dump = 0;
  tap_exp_t    cur;
  int          exp_iv;

  task automatic push_taps(int unsigned base, int m0, int m1, int s);
    for (int m = m0; m <= m1; m++) begin
      tap_exp_t e;
      e.at = base + m;
      e.v  = exp_taps(m, s);
      tap_q.push_back(e);
    end
  endtask

  // Monitor: dump intervals and stamped tap expectations.
  always @(negedge clk) begin
    if (!rst && dump_enable) begin
      if (dump_q.size() == 0) begin
        check("dump_unexpected", dump_enable, 0);
      end else begin
        exp_iv = dump_q.pop_front();
        check("dump_interval", cyc - last_dump, exp_iv);
      end
      last_dump = cyc;
    end
    if (tap_q.size() > 0 && tap_q[0].at == cyc) begin
      cur = tap_q.pop_front();
      check("taps", taps, cur.v);
      check("early_prompt_late", {late, prompt, early}, cur.v[TAPS/2+1:TAPS/2-1]);
    end
  end

  task automatic wait_until(int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic init_prn(output int unsigned t0);
    @(posedge clk);
    #1 prn_key = 10'h3EC; prn_key_enable = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    last_dump = t0;
    prn_key_enable = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_taps"}, taps, 0);
    check({tag, "_elp"}, {late, prompt, early}, 0);
    check({tag, "_dump"}, dump_enable, 0);
    check({tag, "_code_phase"}, code_phase, 0);
    check({tag, "_epoch"}, epoch, 0);
    check({tag, "_epoch_at_tic"}, epoch_at_tic, 0);
    check({tag, "_slew_busy"}, slew_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t0, t0b, tk[0:8], d;
    int iv[9] = '{4, 2046, 2046, 2046, 2046, 2046, 2056, 2046, 2046};
    build_ca();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0; hc_enable = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_all_zero("idle");

    init_prn(t0);
    for (int k = 0; k <= 5; k++) tk[k] = t0 + 4 + 2046 * k;
    d = tk[5];
    tk[6] = d + 2056;
    tk[7] = tk[6] + 2046;
    tk[8] = tk[7] + 2046;
    foreach (iv[i]) dump_q.push_back(iv[i]);
    push_taps(t0, 0, 45, 0);
    push_taps(t0, 4040, 4070, 0);
    push_taps(t0, int'(d - t0) - 30, int'(d - t0) - 1, 0);
    push_taps(t0, int'(d - t0) + 20, int'(d - t0) + 59, 10);

    // TIC on the dump cycle, then mid-period
    wait_until(tk[1]); tic_enable = 1'b1;
    wait_until(tk[1] + 1); tic_enable = 1'b0;
    @(negedge clk);
    check("tic_dump_code_phase", code_phase, 2045);
    check("tic_dump_epoch_at_tic", epoch_at_tic, 1);
    check("epoch_after_dump", epoch, 2);
    wait_until(tk[1] + 100); tic_enable = 1'b1;
    wait_until(tk[1] + 101); tic_enable = 1'b0;
    @(negedge clk);
    check("tic_mid_code_phase", code_phase, 99);
    check("tic_mid_epoch_at_tic", epoch_at_tic, 2);

    // Epoch load and wrap
    wait_until(tk[1] + 300); epoch_load = 1'b1; epoch_load_val = 5'd18;
    wait_until(tk[1] + 301); epoch_load = 1'b0;
    @(negedge clk); check("epoch_load", epoch, 18);
    wait_until(tk[2] + 1); @(negedge clk); check("epoch_19", epoch, 19);
    wait_until(tk[3] + 1); @(negedge clk); check("epoch_wrap", epoch, 0);
    wait_until(tk[4]); epoch_load = 1'b1; epoch_load_val = 5'd5;
    wait_until(tk[4] + 1); epoch_load = 1'b0;
    @(negedge clk); check("epoch_load_on_dump", epoch, 5);

    // Slew of 10 half-chips
    wait_until(tk[4] + 499); @(negedge clk); check("busy_before_slew", slew_busy, 0);
    wait_until(tk[4] + 500); code_slew = 11'd10; slew_enable = 1'b1;
    wait_until(tk[4] + 501); slew_enable = 1'b0;
    @(negedge clk); check("busy_armed", slew_busy, 1);
    wait_until(d + 1); @(negedge clk); check("epoch_after_load", epoch, 6);
    wait_until(d + 8); @(negedge clk); check("busy_last_slew", slew_busy, 1);
    wait_until(d + 9); @(negedge clk); check("busy_done", slew_busy, 0);

    // Slew of 500 interrupted by reset
    wait_until(tk[7] + 300); code_slew = 11'd500; slew_enable = 1'b1;
    wait_until(tk[7] + 301); slew_enable = 1'b0;
    wait_until(tk[8] + 100); @(negedge clk);
    check("busy_mid_slew", slew_busy, 1);
    check("epoch_before_rst", epoch, 9);
    check("code_phase_before_rst", code_phase, 99);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    check("dumps_seen_seg1", dump_q.size(), 0);
    @(posedge clk);
    #1 rst = 1'b0; code_slew = '0;

    init_prn(t0b);
    dump_q.push_back(4);
    dump_q.push_back(2046);
    push_taps(t0b, 0, 45, 0);
    wait_until(t0b + 4 + 2046 + 5);
    @(negedge clk);
    check("dumps_seen_seg2", dump_q.size(), 0);
    check("taps_seen", tap_q.size(), 0);
    check("busy_after_reinit", slew_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
